// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, keeps one imem request outstanding and buffers {pc, word} for decode.
// Optional macro FETCH_BYPASS_EN forwards a returning word straight to decode when the queue is empty.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               active_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        data_mem_q [DEPTH];
    logic [31:0]        pc_mem_q   [DEPTH];
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;

    logic               accept_s;
    logic               rsp_ok_s;
    logic               pop_s;
    logic               push_s;
    logic               bypass_take_s;
    logic [31:0]        rsp_pc_s;
    logic [CNT_W-1:0]   rem_s;

    // active_q holds requests off until the first clock edge after reset release
    assign imem_req_o  = active_q && (state_q == FETCH) && !halt_i && !redirect_i && (count_q < DEPTH_C);
    assign imem_addr_o = pc_q;
    assign accept_s    = imem_req_o && imem_gnt_i;
    assign rsp_ok_s    = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
    assign rsp_pc_s    = pc_q - 32'd4;
    assign pop_s       = instr_valid_q && instr_ready_i && !redirect_i;
    assign push_s      = rsp_ok_s && !bypass_take_s;

`ifdef FETCH_BYPASS_EN
    logic bypass_show_s;
    assign bypass_show_s = rsp_ok_s && (count_q == '0);
    assign bypass_take_s = bypass_show_s && instr_ready_i;
    assign instr_o       = bypass_show_s ? imem_rdata_i : instr_q;
    assign instr_pc_o    = bypass_show_s ? rsp_pc_s : instr_pc_q;
    assign instr_valid_o = instr_valid_q || bypass_show_s;
`else
    assign bypass_take_s = 1'b0;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = instr_valid_q;
`endif

    // Next fetch state; redirect overrides and decides whether an in-flight word must be swallowed
    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            if ((state_q == WAIT || state_q == DISCARD) && !imem_rvalid_i) begin
                state_d = DISCARD;
            end else if (state_q == FETCH && imem_gnt_i) begin
                state_d = DISCARD;
            end else begin
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (accept_s) begin
                        state_d = WAIT;
                    end else begin
                        state_d = FETCH;
                    end
                end
                WAIT, DISCARD: begin
                    if (imem_rvalid_i) begin
                        state_d = FETCH;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // Program counter: redirect target is word aligned, sequential fetch wraps modulo 2^32
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (accept_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end
    end

    // Queue occupancy and pointers; a redirect empties the queue and voids a same-cycle pop
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
        end
    end

    // Next head register: the word being pushed becomes head when nothing older survives this cycle
    always_comb begin
        rem_s         = count_q - CNT_W'(pop_s);
        instr_d       = 32'h0000_0000;
        instr_pc_d    = 32'h0000_0000;
        instr_valid_d = 1'b0;
        if (count_d == '0) begin
            instr_valid_d = 1'b0;
        end else if (rem_s == '0) begin
            instr_d       = imem_rdata_i;
            instr_pc_d    = rsp_pc_s;
            instr_valid_d = 1'b1;
        end else begin
            instr_d       = data_mem_q[rd_ptr_d];
            instr_pc_d    = pc_mem_q[rd_ptr_d];
            instr_valid_d = 1'b1;
        end
    end

    // Control state, PC, queue bookkeeping and registered decode outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            active_q      <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            instr_q       <= 32'h0000_0000;
            instr_pc_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            active_q      <= 1'b1;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Queue storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_q[i] <= 32'h0000_0000;
                pc_mem_q[i]   <= 32'h0000_0000;
            end
        end else if (push_s) begin
            data_mem_q[wr_ptr_q] <= imem_rdata_i;
            pc_mem_q[wr_ptr_q]   <= rsp_pc_s;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a one-cycle-latency memory model and a scoreboard of granted requests.
module tb_fetch_queue;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          grants = 0;
    int          popped = 0;
    int          g0 = 0;
    logic [31:0] key = 32'h0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_pop_pc = 32'h0;
    logic        in_wait = 1'b0;

    always #5 clk = ~clk;

    fetch_queue #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .halt_i        (halt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: settle, score this cycle, advance the edge, then apply the memory response
    task automatic tick();
        logic        acc;
        logic        nv;
        logic [31:0] nd;
        ent_t        e;
        #1;
        acc = imem_req && imem_gnt;
        if (redirect) begin
            sb.delete();
        end else if (instr_valid && instr_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("instr", instr, e.data);
                chk("instr_pc", instr_pc, e.pc);
                popped++;
                last_pop_pc = e.pc;
            end
        end else if (!instr_valid) begin
            chk("idle_instr", instr, 32'h0);
            chk("idle_pc", instr_pc, 32'h0);
        end
        if (acc) begin
            sb.push_back('{pc: imem_addr, data: imem_addr ^ key});
            grants++;
            last_addr = imem_addr;
        end
        nv = imem_gnt;
        nd = imem_addr ^ key;
        @(posedge clk);
        #1;
        imem_rvalid = nv;
        imem_rdata  = nd;
        in_wait     = acc;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
        repeat (2) tick();
        chk("rst_req", imem_req, 32'h0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_valid", instr_valid, 32'h0);

        // Sequential fetch with rdata == addr
        rst_n = 1'b1;
        tick();
        chk("first_req", imem_req, 32'h1);
        chk("first_addr", imem_addr, 32'h0040_0000);
        tick();
        tick();
        chk("first_valid", instr_valid, 32'h1);
        chk("first_instr", instr, 32'h0040_0000);
        chk("first_ipc", instr_pc, 32'h0040_0000);
        popped = 0;
        repeat (12) tick();
        chk("throughput", popped, 32'd6);
        chk("seq_last_pc", last_pop_pc, 32'h0040_0014);

        // Fill the queue with decode stalled
        key = 32'h5A5A_5A5A;
        instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0040_1000;
        tick();
        redirect = 1'b0; grants = 0;
        repeat (14) tick();
        chk("full_grants", grants, 32'd4);
        chk("full_req", imem_req, 32'h0);
        chk("full_head_pc", instr_pc, 32'h0040_1000);
        chk("full_head_instr", instr, 32'h0040_1000 ^ 32'h5A5A_5A5A);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        repeat (6) tick();
        chk("refill_grants", grants, 32'd5);
        chk("refill_addr", last_addr, 32'h0040_1010);
        chk("refill_req", imem_req, 32'h0);

        // Redirect in the same cycle as rvalid
        instr_ready = 1'b1;
        for (int i = 0; i < 12 && !in_wait; i++) tick();
        chk("rv_wait", in_wait, 32'h1);
        redirect = 1'b1; redirect_pc = 32'h0040_0103;
        tick();
        redirect = 1'b0;
        #1;
        chk("rv_valid", instr_valid, 32'h0);
        chk("rv_addr", imem_addr, 32'h0040_0100);
        popped = 0;
        repeat (8) tick();
        chk("rv_popped", popped, 32'd3);
        chk("rv_last_pc", last_pop_pc, 32'h0040_0108);

        // Redirect in the grant cycle goes through DISCARD
        for (int i = 0; i < 6 && !imem_req; i++) tick();
        chk("gr_req", imem_req, 32'h1);
        redirect = 1'b1; redirect_pc = 32'h0040_3000;
        tick();
        redirect = 1'b0;
        #1;
        chk("gr_valid", instr_valid, 32'h0);
        chk("gr_disc_req", imem_req, 32'h0);
        tick();
        chk("gr_req2", imem_req, 32'h1);
        chk("gr_addr", imem_addr, 32'h0040_3000);
        popped = 0;
        repeat (6) tick();
        chk("gr_popped", popped, 32'd2);
        chk("gr_last_pc", last_pop_pc, 32'h0040_3004);

        // Halt while a fetch is outstanding
        for (int i = 0; i < 6 && !in_wait; i++) tick();
        chk("h_wait", in_wait, 32'h1);
        halt = 1'b1; g0 = grants; popped = 0;
        repeat (10) tick();
        chk("h_grants", grants, g0);
        chk("h_req", imem_req, 32'h0);
        chk("h_popped", popped, 32'd1);
        chk("h_sb_empty", 32'(sb.size()), 32'd0);
        halt = 1'b0;
        #1;
        chk("h_release_req", imem_req, 32'h1);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 6 && !imem_req; i++) tick();
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        popped = 0;
        repeat (6) tick();
        chk("wrap_popped", popped, 32'd3);
        chk("wrap_last_pc", last_pop_pc, 32'h0000_0004);

        // Reset in the middle of an outstanding fetch
        for (int i = 0; i < 6 && !in_wait; i++) tick();
        chk("mr_wait", in_wait, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", instr_valid, 32'h0);
        chk("mr_req", imem_req, 32'h0);
        chk("mr_addr", imem_addr, RST_PC);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_req2", imem_req, 32'h1);
        chk("mr_addr2", imem_addr, RST_PC);
        popped = 0;
        repeat (4) tick();
        chk("mr_popped", popped, 32'd1);
        chk("mr_last_pc", last_pop_pc, RST_PC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage placed directly upstream of the instruction decoder. It owns the program counter, issues word requests to instruction memory, buffers returned words with their PCs in a small FIFO, and presents one instruction at a time to decode with a valid/ready handshake. Branch, jump and jr resolution redirect it through a single redirect port, which flushes all queued and in-flight fetches.

## Interface
- RESET_PC, 32'h0040_0000, PC fetched first after reset
- DEPTH, 4, queue entries; power of two, 2..16

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, held until granted
- imem_addr  out  32  word address of request, PC with [1:0]=00
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid; exactly 1 cycle after the matching grant
- imem_rdata  in  32  instruction word
- instr  out  32  instruction to decoder; 32'h0000_0000 (NOP) when not valid
- instr_pc  out  32  PC of instr; 0 when not valid
- instr_valid  out  1  instr/instr_pc hold a real instruction
- instr_ready  in  1  decoder consumes when valid & ready
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] forced to 00
- halt  in  1  level; while high no new requests issue (syscall exit / break)

## Operation
- FSM states: FETCH, WAIT, DISCARD. Reset state FETCH.
- FETCH: imem_req = !halt && !redirect && (count < DEPTH). On imem_gnt: pc += 4 (mod 2^32), go WAIT.
- WAIT: imem_req = 0. On imem_rvalid: push {pc_of_request, imem_rdata}, go FETCH. At most one fetch outstanding.
- DISCARD: imem_req = 0. On imem_rvalid: drop data, go FETCH.
- Space check: in FETCH, count < DEPTH guarantees a slot, since only one request is ever outstanding.
- Redirect (highest priority): queue cleared (count=0), pc := {redirect_pc[31:2],2'b00}. If state is WAIT, or imem_gnt is seen in the redirect cycle, go DISCARD; if DISCARD with no rvalid, stay DISCARD; else FETCH. Any rvalid in the redirect cycle is dropped. A pop in the same cycle is void.
- Pop: instr_valid && instr_ready removes the head. Push and pop in one cycle leave count unchanged.
- Halt does not cancel an outstanding fetch; its data is still enqueued. Queued entries keep draining to decode.
- Head outputs are registered from the queue; empty queue drives instr = 0, instr_pc = 0, instr_valid = 0.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, instr 0, instr_pc 0, instr_valid 0, count 0, pc RESET_PC, state FETCH.
- First imem_req rises in the first cycle after rst_n deasserts.
- Grant at cycle n -> rvalid at n+1 -> instr_valid at n+2 (no bypass).
- Sustained throughput: one instruction per 2 cycles with single-outstanding protocol.
- Redirect at cycle n -> instr_valid low at n+1; earliest new request at n+1 (FETCH) or n+2 (via DISCARD).
- Asserting rst_n low mid-fetch clears everything immediately; a late rvalid after reset is ignored (state FETCH, no request outstanding).

## Configuration
- FETCH_BYPASS_EN defined: when queue is empty and imem_rvalid arrives (not discarded, no redirect), imem_rdata and its PC drive instr/instr_pc/instr_valid combinationally that cycle; if instr_ready is high the word is consumed and not enqueued, otherwise it is enqueued. Latency grant->valid becomes 1 cycle.
- Not defined: all data passes through the queue; outputs purely registered; latency 2 cycles.

## Test plan
- Reset release, imem_gnt always 1, rdata = addr: first instr = 32'h0040_0000 with instr_pc 32'h0040_0000, then 0x00400004, 0x00400008 in order.
- instr_ready held 0 with DEPTH=4: exactly 4 grants, imem_req stays 0, count 4; one pop -> single further request at PC+16.
- Redirect to 32'h0040_0103 in the same cycle as rvalid: that data dropped, queue empty next cycle, next imem_addr = 32'h0040_0100.
- Redirect in the grant cycle: the following rvalid is discarded (DISCARD), no instruction from the old path ever reaches instr.
- halt asserted during WAIT: outstanding word enqueued and delivered, no further imem_req until halt drops.
- Redirect from pc 32'hFFFF_FFFC: next sequential imem_addr after grant wraps to 32'h0000_0000.
